// File: rtl/serdes_tx_serializer.sv
// Parallel-to-serial transmit stage: a small FIFO feeds an LSB-first shifter
// that streams words gaplessly and flags bit 0 of each word with frame_start.
module serdes_tx_serializer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              busy,
  output logic [FIFO_AW:0]  fifo_level
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned LVL_W = FIFO_AW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  head;
  logic               fifo_empty;
  logic               word_done;
  logic               push;
  logic               pop;

  assign fifo_empty = (level == '0);
  assign in_ready   = (level != LVL_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign word_done  = (state == IDLE) || (bit_cnt == CNT_W'(DATA_W));
  // Pop only uses the registered level, so a word is never popped on its push edge
  assign pop        = en && word_done && !fifo_empty;
  assign head       = mem[rd_ptr];
  assign busy       = ((state == SHIFT) && (bit_cnt < CNT_W'(DATA_W))) || !fifo_empty;
  assign fifo_level = level;

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Shifter FSM; loading the next word on the final-bit boundary keeps words gapless
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if ((state == SHIFT) && (bit_cnt < CNT_W'(DATA_W))) begin
      ser_out     <= shreg[0];
      shreg       <= shreg >> 1;
      bit_cnt     <= bit_cnt + CNT_W'(1);
      ser_valid   <= 1'b1;
      frame_start <= 1'b0;
    end else if (!fifo_empty) begin
      ser_out     <= head[0];
      shreg       <= head >> 1;
      bit_cnt     <= CNT_W'(1);
      ser_valid   <= 1'b1;
      frame_start <= 1'b1;
      state       <= SHIFT;
    end else begin
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      state       <= IDLE;
    end
  end

endmodule
